// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned DEF_PC_W  = 16;
  localparam int unsigned DEF_OFF_W = 6;

  localparam logic [OPC_W-1:0] OP_BRANCH = 4'b1100;
  localparam logic [OPC_W-1:0] OP_NOP    = 4'b0000;

  // Fetch-stage control states.
  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    BR_HOLD    = 2'd1,
    BR_RESOLVE = 2'd2
  } state_t;

  // Payload presented to decode: the instruction and its bubble marker.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               bubble;
  } dec_word_t;

  // Value decode sees after reset: a NOP marked as a bubble.
  localparam dec_word_t DEC_RESET = '{instr: {OP_NOP, (INSTR_W-OPC_W)'(0)}, bubble: 1'b1};

  // True when the fetched word carries the branch opcode.
  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W] == OP_BRANCH;
  endfunction

endpackage

// File: rtl/if_pc_unit.sv
// Program counter: register, sequential increment and branch-target load.
module if_pc_unit
  import if_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     OFF_W    = DEF_OFF_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             br_load,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  pc
);

  localparam int unsigned EXT_W = PC_W - OFF_W;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_target;

  // pc already points one past the branch when the target is formed.
  assign pc_inc    = pc_q + PC_W'(1);
  assign off_ext   = {{EXT_W{offset[OFF_W-1]}}, offset};
  assign br_target = pc_q + off_ext;

  // Load select: branch redirect wins over sequential increment.
  always_comb begin
    pc_nx = pc_q;
    if (br_load) begin
      pc_nx = br_target;
    end else if (inc_en) begin
      pc_nx = pc_inc;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_nx;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetches one word per handshake, presents it to
// decode for one cycle and freezes across branches until decode resolves them.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     OFF_W    = DEF_OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               instruction_decode_en,
  output logic [PC_W-1:0]    pc_out,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_offset_imm
);

  state_t          state_q;
  state_t          state_nx;
  dec_word_t       out_q;
  dec_word_t       out_nx;
  logic [PC_W-1:0] pc_out_q;
  logic [PC_W-1:0] pc_out_nx;
  logic [PC_W-1:0] pc;
  logic            xfer;
  logic            pc_inc_en;
  logic            br_load;

  if_pc_unit #(
    .PC_W     (PC_W),
    .OFF_W    (OFF_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (pc_inc_en),
    .br_load (br_load),
    .offset  (branch_offset_imm),
    .pc      (pc)
  );

  // Memory request is combinational so the handshake completes in one cycle.
  assign imem_req  = (state_q == FETCH) & ~stall_in & rst;
  assign imem_addr = pc;
  assign xfer      = imem_req & imem_ready;

  // Next state, next decode payload and PC control; a stall holds everything.
  always_comb begin
    state_nx  = state_q;
    out_nx    = out_q;
    pc_out_nx = pc_out_q;
    pc_inc_en = 1'b0;
    br_load   = 1'b0;
    if (!stall_in) begin
      unique case (state_q)
        FETCH: begin
          if (xfer) begin
            out_nx.instr  = imem_rdata;
            out_nx.bubble = 1'b0;
            pc_out_nx     = pc;
            pc_inc_en     = 1'b1;
            if (is_branch(imem_rdata)) begin
              state_nx = BR_HOLD;
            end
          end else begin
            out_nx.bubble = 1'b1;
          end
        end
        BR_HOLD: begin
          // Branch was presented for its single cycle; bubble from here on.
          out_nx.bubble = 1'b1;
          state_nx      = BR_RESOLVE;
        end
        BR_RESOLVE: begin
          out_nx.bubble = 1'b1;
          br_load       = branch_taken;
          state_nx      = FETCH;
        end
        default: begin
          state_nx = FETCH;
        end
      endcase
    end
  end

  // State and decode-facing output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FETCH;
      out_q    <= DEC_RESET;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_nx;
      out_q    <= out_nx;
      pc_out_q <= pc_out_nx;
    end
  end

  assign instruction_out       = out_q.instr;
  assign instruction_decode_en = out_q.bubble;
  assign pc_out                = pc_out_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle vector table plus a scoreboard
// of fetched words that must appear on the decode interface.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruction_out;
  logic        instruction_decode_en;
  logic [15:0] pc_out;
  logic        branch_taken;
  logic [5:0]  branch_offset_imm;

  if_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall_in              (stall_in),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .imem_ready            (imem_ready),
    .imem_rdata            (imem_rdata),
    .instruction_out       (instruction_out),
    .instruction_decode_en (instruction_decode_en),
    .pc_out                (pc_out),
    .branch_taken          (branch_taken),
    .branch_offset_imm     (branch_offset_imm)
  );

  always #5 clk = ~clk;

  // Instruction memory model: 16 programmable words, fixed pattern above.
  logic [15:0] mem [16];

  always_comb begin
    if (imem_addr < 16'd16) imem_rdata = mem[imem_addr[3:0]];
    else                    imem_rdata = {4'h2, imem_addr[11:0]};
  end

  function automatic logic [15:0] word(input logic [15:0] a);
    if (a < 16'd16) return mem[a[3:0]];
    return {4'h2, a[11:0]};
  endfunction

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        ready;
    logic        taken;
    logic [5:0]  off;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_en;
  } vec_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          total;
  int          passed;
  logic        pending;
  logic        prev_rst;
  logic [15:0] last_instr;

  function automatic vec_t mkv(input logic r, input logic s, input logic rd, input logic tk,
                               input logic [5:0] o, input logic q, input logic [15:0] a,
                               input logic e);
    vec_t t;
    t.rst = r; t.stall = s; t.ready = rd; t.taken = tk; t.off = o;
    t.exp_req = q; t.exp_addr = a; t.exp_en = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle: check what the previous edge produced, drive this cycle, check comb outputs.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (!prev_rst) begin
      last_instr = 16'h0000;
      pending    = 1'b0;
    end
    if (pending) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL %s scoreboard: empty on expected output", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, " instr"}, 32'(instruction_out), 32'(e.instr));
        chk({tag, " pc_out"}, 32'(pc_out), 32'(e.pc));
        last_instr = e.instr;
      end
    end else begin
      chk({tag, " instr_hold"}, 32'(instruction_out), 32'(last_instr));
    end
    rst               = v.rst;
    stall_in          = v.stall;
    imem_ready        = v.ready;
    branch_taken      = v.taken;
    branch_offset_imm = v.off;
    #1;
    chk({tag, " req"}, 32'(imem_req), 32'(v.exp_req));
    if (v.exp_req) chk({tag, " addr"}, 32'(imem_addr), 32'(v.exp_addr));
    chk({tag, " decode_en"}, 32'(instruction_decode_en), 32'(v.exp_en));
    pending = v.exp_req & v.ready & v.rst;
    if (pending) sb.push_back('{instr: word(v.exp_addr), pc: v.exp_addr});
    prev_rst = v.rst;
  endtask

  initial begin
    total = 0; passed = 0;
    pending = 1'b0; prev_rst = 1'b0; last_instr = 16'h0000;
    rst = 1'b0; stall_in = 1'b0; imem_ready = 1'b0;
    branch_taken = 1'b0; branch_offset_imm = 6'h00;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'hC005; mem[5] = 16'h5555; mem[7] = 16'hC005; mem[10] = 16'hAAAA;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", 32'(imem_req), 32'h0);
    chk("reset addr", 32'(imem_addr), 32'h0);
    chk("reset decode_en", 32'(instruction_decode_en), 32'h1);
    chk("reset instr", 32'(instruction_out), 32'h0);
    chk("reset pc_out", 32'(pc_out), 32'h0);

    // Streaming fetch, then ready low for three cycles.
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd1, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd2, L));
    tbl.push_back(mkv(H, L, L, L, 6'h00, H, 16'd3, L));
    tbl.push_back(mkv(H, L, L, L, 6'h00, H, 16'd3, H));
    tbl.push_back(mkv(H, L, L, L, 6'h00, H, 16'd3, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd3, H));
    // Branch at 4 taken, offset +5 -> 10.
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd4, L));
    tbl.push_back(mkv(H, L, H, H, 6'h05, L, 16'd0, L));
    tbl.push_back(mkv(H, L, H, H, 6'h05, L, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd10, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd11, L));
    // Reset mid-stream, refetch to 4; taken -1 loops to 4, then not taken -> 5.
    tbl.push_back(mkv(L, L, H, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd1, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd2, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd3, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd4, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, L, H, H, 6'h3F, L, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd4, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, L, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd5, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd6, L));
    // Branch at 7; stall two cycles in resolve with a decoy offset, then +5 -> 13.
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd7, L));
    tbl.push_back(mkv(H, L, L, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, H, H, H, 6'h01, L, 16'd0, H));
    tbl.push_back(mkv(H, H, H, H, 6'h01, L, 16'd0, H));
    tbl.push_back(mkv(H, L, H, H, 6'h05, L, 16'd0, H));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd13, H));
    // Stall in FETCH with ready pulses: nothing moves.
    tbl.push_back(mkv(H, H, H, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, H, H, L, 6'h00, L, 16'd0, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd14, L));
    tbl.push_back(mkv(H, L, H, L, 6'h00, H, 16'd15, L));

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // PC wrap: branch at 0 with offset -2 lands on 0xFFFF, next fetch is 0x0000.
    mem[0] = 16'hC03E;
    step("w0", mkv(L, L, H, L, 6'h00, L, 16'd0, L));
    step("w1", mkv(H, L, H, L, 6'h00, H, 16'd0, H));
    step("w2", mkv(H, L, H, L, 6'h00, L, 16'd0, L));
    step("w3", mkv(H, L, H, H, 6'h3E, L, 16'd0, H));
    step("w4", mkv(H, L, L, L, 6'h00, H, 16'hFFFF, H));
    step("w5", mkv(H, L, H, L, 6'h00, H, 16'hFFFF, H));
    step("w6", mkv(H, L, L, L, 6'h00, H, 16'h0000, L));
    // Reset while a request is pending at a nonzero PC.
    mem[0] = 16'h1111;
    step("r0", mkv(H, L, H, L, 6'h00, H, 16'd0, H));
    step("r1", mkv(H, L, H, L, 6'h00, H, 16'd1, L));
    step("r2", mkv(H, L, L, L, 6'h00, H, 16'd2, L));
    step("r3", mkv(L, L, H, L, 6'h00, L, 16'd0, H));
    step("r4", mkv(H, L, L, L, 6'h00, H, 16'd0, H));
    chk("post-reset pc_out", 32'(pc_out), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
